// File: rtl/pj_mem_responder.sv
// Behavioural memory and bus slave for the picoJava-II memory interface:
// programmable wait states, wrapping bursts, and memory/IO error windows.
module pj_mem_responder #(
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned BEAT_GAP    = 0,
  parameter logic [29:0] MEM_ERR_LO  = 30'h3FFF_0000,
  parameter logic [29:0] MEM_ERR_HI  = 30'h3FFF_00FF,
  parameter logic [29:0] IO_ERR_LO   = 30'h3FFF_1000,
  parameter logic [29:0] IO_ERR_HI   = 30'h3FFF_10FF
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        pj_tv,
  input  logic [3:0]  pj_type,
  input  logic [1:0]  pj_size,
  input  logic [29:0] pj_address,
  input  logic [31:0] pj_data_out,
  input  logic        pj_standby_out,
  output logic [1:0]  pj_ack,
  output logic [31:0] pj_data_in,
  output logic        err_pulse
);

  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES - 1);
  localparam logic [3:0]  GAP_LAST  = 4'(BEAT_GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BEAT, ST_GAP} state_t;

  state_t      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [2:0]  beats_q, beats_d;
  logic [1:0]  wrap_q, wrap_d;
  logic        write_q, write_d;
  logic [1:0]  err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [31:0] mem_q [MEM_WORDS];
  logic        mem_we_s;
  logic [29:0] idx_full_s;
  logic [AW-1:0] idx_s;
  logic [2:0]  beats_s;
  logic [1:0]  wrap_s;
  logic        illegal_s;
  logic        mem_win_s;
  logic        io_win_s;
  logic [1:0]  err_s;
  logic        unused_s;

  assign idx_full_s = addr_q % 30'(MEM_WORDS);
  assign idx_s      = idx_full_s[AW-1:0];
  assign unused_s   = ^{pj_type[3], idx_full_s[29:AW]};

  // Decode the transaction offered on the bus: beat count, wrap mask, error class.
  always_comb begin
    beats_s   = 3'd1;
    wrap_s    = 2'b00;
    illegal_s = 1'b0;
    case (pj_type[2:0])
      3'b000: begin
        beats_s = 3'd2;
        wrap_s  = 2'b01;
      end
      3'b100, 3'b101: begin
        beats_s = 3'd4;
        wrap_s  = 2'b11;
      end
      3'b010, 3'b110, 3'b111: begin
        beats_s = 3'd1;
        wrap_s  = 2'b00;
      end
      default: illegal_s = 1'b1;
    endcase
    mem_win_s = (pj_address >= MEM_ERR_LO) && (pj_address <= MEM_ERR_HI);
    io_win_s  = (pj_address >= IO_ERR_LO) && (pj_address <= IO_ERR_HI);
    // Illegal encodings answer as a memory error; the memory window wins any overlap.
    if (illegal_s || (pj_size == 2'b11) || mem_win_s) begin
      err_s = 2'b10;
    end else if (io_win_s) begin
      err_s = 2'b11;
    end else begin
      err_s = 2'b00;
    end
  end

  // Next-state and bus outputs; acks are gated by pj_tv so an abort takes effect at once.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    wrap_d     = wrap_q;
    write_d    = write_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    pj_ack     = 2'b00;
    pj_data_in = 32'h0000_0000;
    err_pulse  = 1'b0;
    mem_we_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pj_tv && !pj_standby_out) begin
          addr_d  = pj_address;
          beats_d = (err_s != 2'b00) ? 3'd1 : beats_s;
          wrap_d  = wrap_s;
          write_d = pj_type[0];
          err_d   = err_s;
          cnt_d   = 4'd0;
          state_d = (WAIT_STATES == 0) ? ST_BEAT : ST_WAIT;
        end else if (pj_tv && reset_l) begin
          err_pulse = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!pj_tv) begin
          state_d = ST_IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_BEAT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (!pj_tv) begin
          state_d = ST_IDLE;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_BEAT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_BEAT: begin
        if (!pj_tv) begin
          state_d = ST_IDLE;
        end else if (err_q != 2'b00) begin
          pj_ack    = err_q;
          err_pulse = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          pj_ack = 2'b01;
          if (write_q) begin
            mem_we_s = 1'b1;
          end else begin
            pj_data_in = mem_q[idx_s];
          end
          beats_d = beats_q - 3'd1;
          // Increment only the bits inside the aligned burst group.
          addr_d  = (addr_q & ~{28'h0, wrap_q}) | ((addr_q + 30'd1) & {28'h0, wrap_q});
          if (beats_q == 3'd1) begin
            state_d = ST_IDLE;
          end else if (BEAT_GAP == 0) begin
            state_d = ST_BEAT;
          end else begin
            cnt_d   = 4'd0;
            state_d = ST_GAP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= ST_IDLE;
      addr_q  <= 30'h0;
      beats_q <= 3'd0;
      wrap_q  <= 2'b00;
      write_q <= 1'b0;
      err_q   <= 2'b00;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      wrap_q  <= wrap_d;
      write_q <= write_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage survives reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= pj_data_out;
    end
  end

endmodule

// File: tb/tb_pj_mem_responder.sv
// Directed bench for pj_mem_responder: single-beat vector table plus
// hand-written burst, gap, abort, standby, back-to-back and reset sequences.
module tb_pj_mem_responder;

  logic        clk;
  logic        reset_l;
  logic        tv_a, tv_g;
  logic [3:0]  ty;
  logic [1:0]  sz;
  logic [29:0] ad;
  logic [31:0] dout;
  logic        sb;
  logic [1:0]  ack_a, ack_g;
  logic [31:0] din_a, din_g;
  logic        err_a, err_g;

  int checks = 0;
  int errors = 0;

  pj_mem_responder u_dut (
    .clk(clk), .reset_l(reset_l), .pj_tv(tv_a), .pj_type(ty), .pj_size(sz),
    .pj_address(ad), .pj_data_out(dout), .pj_standby_out(sb),
    .pj_ack(ack_a), .pj_data_in(din_a), .err_pulse(err_a)
  );

  pj_mem_responder #(.BEAT_GAP(1)) u_gap (
    .clk(clk), .reset_l(reset_l), .pj_tv(tv_g), .pj_type(ty), .pj_size(sz),
    .pj_address(ad), .pj_data_out(dout), .pj_standby_out(sb),
    .pj_ack(ack_g), .pj_data_in(din_g), .err_pulse(err_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  t;
    logic [1:0]  s;
    logic [29:0] a;
    logic [31:0] wd;
    logic [1:0]  exp_ack;
    logic [31:0] exp_data;
    int          exp_err;
  } vec_t;

  vec_t vt [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offers one transaction and records every ack; tv drops after the expected last ack.
  task automatic run_txn(input bit g, input logic [3:0] t, input logic [1:0] s,
                         input logic [29:0] a, input logic [3:0][31:0] wd,
                         input int exp_beats, input bit sb_mid,
                         output int nack, output logic [3:0][1:0] acks,
                         output logic [3:0][31:0] rd, output logic [3:0][7:0] cy,
                         output int nerr);
    int cyc;
    bit done;
    logic [1:0] ak;
    logic [31:0] dn;
    logic ep;
    nack = 0; nerr = 0; acks = '0; rd = '0; cy = '0; cyc = 0; done = 1'b0;
    @(posedge clk); #1;
    ty = t; sz = s; ad = a; dout = wd[0];
    if (g) tv_g = 1'b1; else tv_a = 1'b1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      ak = g ? ack_g : ack_a;
      dn = g ? din_g : din_a;
      ep = g ? err_g : err_a;
      if (ak != 2'b00 && nack < 4) begin
        acks[nack] = ak;
        rd[nack]   = dn;
        cy[nack]   = 8'(cyc);
        if (ep) nerr++;
        nack++;
        if (ak != 2'b01 || nack >= exp_beats) done = 1'b1;
      end
      @(posedge clk); #1;
      if (sb_mid && cyc == 2) sb = 1'b1;
      if (nack < 4) dout = wd[nack];
    end
    tv_a = 1'b0; tv_g = 1'b0; sb = 1'b0;
  endtask

  task automatic count_acks(input bit g, input int ncyc, output int n);
    n = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if ((g ? ack_g : ack_a) != 2'b00) n++;
    end
  endtask

  initial begin
    int nack, nerr, n;
    logic [3:0][1:0]  acks;
    logic [3:0][31:0] rd;
    logic [3:0][7:0]  cy;
    logic [3:0][31:0] wd;
    bit found;

    vt[0]  = '{4'b0111, 2'b10, 30'h100,        32'hCAFE_0001, 2'b01, 32'h0,         0};
    vt[1]  = '{4'b0110, 2'b10, 30'h100,        32'h0,         2'b01, 32'hCAFE_0001, 0};
    vt[2]  = '{4'b0111, 2'b10, 30'h0FF,        32'h0000_00FF, 2'b01, 32'h0,         0};
    vt[3]  = '{4'b0010, 2'b10, 30'h0FF,        32'h0,         2'b01, 32'h0000_00FF, 0};
    vt[4]  = '{4'b0110, 2'b10, 30'h3FFF_0000,  32'h0,         2'b10, 32'h0,         1};
    vt[5]  = '{4'b0111, 2'b10, 30'h3FFF_10FF,  32'hDEAD_BEEF, 2'b11, 32'h0,         1};
    vt[6]  = '{4'b0110, 2'b10, 30'h0FF,        32'h0,         2'b01, 32'h0000_00FF, 0};
    vt[7]  = '{4'b0111, 2'b10, 30'h3FFF_00FF,  32'h1234_5678, 2'b10, 32'h0,         1};
    vt[8]  = '{4'b0010, 2'b10, 30'h0FF,        32'h0,         2'b01, 32'h0000_00FF, 0};
    vt[9]  = '{4'b0001, 2'b10, 30'h100,        32'h0,         2'b10, 32'h0,         1};
    vt[10] = '{4'b0011, 2'b10, 30'h100,        32'h0,         2'b10, 32'h0,         1};
    vt[11] = '{4'b0110, 2'b11, 30'h100,        32'h0,         2'b10, 32'h0,         1};
    vt[12] = '{4'b0111, 2'b10, 30'h1100,       32'hBEEF_0002, 2'b01, 32'h0,         0};
    vt[13] = '{4'b0110, 2'b10, 30'h100,        32'h0,         2'b01, 32'hBEEF_0002, 0};
    vt[14] = '{4'b0110, 2'b10, 30'h3FFF_1000,  32'h0,         2'b11, 32'h0,         1};
    vt[15] = '{4'b0111, 2'b10, 30'h040,        32'h4040_4040, 2'b01, 32'h0,         0};
    vt[16] = '{4'b0111, 2'b10, 30'h041,        32'h4141_4141, 2'b01, 32'h0,         0};

    reset_l = 1'b0; tv_a = 1'b0; tv_g = 1'b0; ty = 4'h0; sz = 2'b00;
    ad = 30'h0; dout = 32'h0; sb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", 32'(ack_a), 32'h0);
    check("reset_data", din_a, 32'h0);
    check("reset_err", 32'(err_a), 32'h0);
    check("reset_ack_gap", 32'(ack_g), 32'h0);
    reset_l = 1'b1;

    for (int i = 0; i < 17; i++) begin
      wd = {4{vt[i].wd}};
      run_txn(1'b0, vt[i].t, vt[i].s, vt[i].a, wd, 1, 1'b0, nack, acks, rd, cy, nerr);
      check($sformatf("vec%0d_nack", i), 32'(nack), 32'd1);
      check($sformatf("vec%0d_ack", i), 32'(acks[0]), 32'(vt[i].exp_ack));
      check($sformatf("vec%0d_data", i), rd[0], vt[i].exp_data);
      check($sformatf("vec%0d_latency", i), 32'(cy[0]), 32'd4);
      check($sformatf("vec%0d_errpulse", i), 32'(nerr), 32'(vt[i].exp_err));
    end

    // Wrapping 4-beat read after a 4-beat write preload.
    for (int k = 0; k < 4; k++) wd[k] = 32'hA000_0000 + 32'(k);
    run_txn(1'b0, 4'b0101, 2'b10, 30'h200, wd, 4, 1'b0, nack, acks, rd, cy, nerr);
    check("wr4_nack", 32'(nack), 32'd4);
    wd = '0;
    run_txn(1'b0, 4'b0100, 2'b10, 30'h202, wd, 4, 1'b0, nack, acks, rd, cy, nerr);
    check("rd4_nack", 32'(nack), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rd4_ack%0d", k), 32'(acks[k]), 32'h1);
      check($sformatf("rd4_data%0d", k), rd[k], 32'hA000_0000 + 32'((k + 2) % 4));
      check($sformatf("rd4_cycle%0d", k), 32'(cy[k]), 32'(4 + k));
    end
    count_acks(1'b0, 4, n);
    check("rd4_idle_after", 32'(n), 32'd0);

    // Two-beat wrapping read starting at the odd word.
    run_txn(1'b0, 4'b0000, 2'b10, 30'h041, wd, 2, 1'b0, nack, acks, rd, cy, nerr);
    check("rd2_nack", 32'(nack), 32'd2);
    check("rd2_data0", rd[0], 32'h4141_4141);
    check("rd2_data1", rd[1], 32'h4040_4040);
    check("rd2_cycle1", 32'(cy[1]), 32'd5);

    // Burst with one gap cycle between beats.
    for (int k = 0; k < 4; k++) wd[k] = 32'(k + 1);
    run_txn(1'b1, 4'b0101, 2'b10, 30'h300, wd, 4, 1'b0, nack, acks, rd, cy, nerr);
    check("gapwr_nack", 32'(nack), 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("gapwr_cycle%0d", k), 32'(cy[k]), 32'(4 + 2 * k));
    wd = '0;
    run_txn(1'b1, 4'b0100, 2'b10, 30'h300, wd, 4, 1'b0, nack, acks, rd, cy, nerr);
    check("gaprd_nack", 32'(nack), 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("gaprd_data%0d", k), rd[k], 32'(k + 1));
    check("gaprd_errpulse", 32'(nerr), 32'd0);

    // Abort a 2-beat read after its first ack.
    @(posedge clk); #1;
    ty = 4'b0000; sz = 2'b10; ad = 30'h041; tv_a = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (ack_a != 2'b00) found = 1'b1;
    end
    check("abort_first_ack_seen", 32'(found), 32'd1);
    check("abort_first_data", din_a, 32'h4141_4141);
    @(posedge clk); #1;
    tv_a = 1'b0;
    count_acks(1'b0, 6, n);
    check("abort_no_more_acks", 32'(n), 32'd0);
    run_txn(1'b0, 4'b0010, 2'b10, 30'h040, wd, 1, 1'b0, nack, acks, rd, cy, nerr);
    check("after_abort_nack", 32'(nack), 32'd1);
    check("after_abort_data", rd[0], 32'h4040_4040);
    check("after_abort_latency", 32'(cy[0]), 32'd4);

    // Back-to-back with pj_tv held across both transactions.
    @(posedge clk); #1;
    ty = 4'b0110; sz = 2'b10; ad = 30'h100; tv_a = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (ack_a != 2'b00) found = 1'b1;
    end
    check("b2b_first_ack_seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    ty = 4'b0010; ad = 30'h040;
    @(negedge clk);
    check("b2b_gap_cycle_ack", 32'(ack_a), 32'h0);
    n = 1; found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      n++;
      if (ack_a != 2'b00) found = 1'b1;
    end
    check("b2b_second_spacing", 32'(n), 32'd4);
    check("b2b_second_data", din_a, 32'h4040_4040);
    @(posedge clk); #1;
    tv_a = 1'b0;

    // Standby in IDLE rejects the request every cycle.
    @(posedge clk); #1;
    sb = 1'b1; ty = 4'b0110; ad = 30'h100; tv_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("standby_err%0d", k), 32'(err_a), 32'h1);
      check($sformatf("standby_ack%0d", k), 32'(ack_a), 32'h0);
    end
    @(posedge clk); #1;
    tv_a = 1'b0; sb = 1'b0;
    run_txn(1'b0, 4'b0110, 2'b10, 30'h100, wd, 1, 1'b1, nack, acks, rd, cy, nerr);
    check("standby_mid_nack", 32'(nack), 32'd1);
    check("standby_mid_data", rd[0], 32'hBEEF_0002);

    // Reset during WAIT of a 4-beat read.
    @(posedge clk); #1;
    ty = 4'b0100; sz = 2'b10; ad = 30'h200; tv_a = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_l = 1'b0;
    #1;
    check("rst_wait_ack", 32'(ack_a), 32'h0);
    check("rst_wait_data", din_a, 32'h0);
    tv_a = 1'b0;
    @(posedge clk); #1;
    reset_l = 1'b1;
    count_acks(1'b0, 8, n);
    check("rst_wait_no_acks", 32'(n), 32'd0);

    // Reset during a BEAT drops the outputs at once.
    @(posedge clk); #1;
    ty = 4'b0100; sz = 2'b10; ad = 30'h202; tv_a = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (ack_a != 2'b00) found = 1'b1;
    end
    check("rst_beat_pre_data", din_a, 32'hA000_0002);
    #1;
    reset_l = 1'b0;
    #1;
    check("rst_beat_ack", 32'(ack_a), 32'h0);
    check("rst_beat_data", din_a, 32'h0);
    tv_a = 1'b0;
    @(posedge clk); #1;
    reset_l = 1'b1;
    count_acks(1'b0, 8, n);
    check("rst_beat_no_acks", 32'(n), 32'd0);
    run_txn(1'b0, 4'b0110, 2'b10, 30'h200, wd, 1, 1'b0, nack, acks, rd, cy, nerr);
    check("post_reset_data", rd[0], 32'hA000_0000);
    check("post_reset_latency", 32'(cy[0]), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pj_mem_responder.md
Name: pj_mem_responder

Overview:
- Behavioural memory and bus slave that sits directly downstream of the picoJava-II core's memory interface.
- Accepts each pj_tv transaction, applies programmable wait states, and drives pj_ack and pj_data_in.
- Returns exactly the ack count each transaction type requires; the bus monitor observes these acks alongside the core.
- Contains word-addressed storage, and signals memory-error and IO-error windows with error acks.

Parameters:
- MEM_WORDS, 4096: storage depth in 32-bit words. Address index is pj_address modulo MEM_WORDS.
- WAIT_STATES, 2: idle cycles between accepting a transaction and its first ack (0..15).
- BEAT_GAP, 0: idle cycles inserted between consecutive beats of a burst (0..3).
- MEM_ERR_LO, 30'h3FFF_0000: low bound of the memory-error window, inclusive.
- MEM_ERR_HI, 30'h3FFF_00FF: high bound of the memory-error window, inclusive.
- IO_ERR_LO, 30'h3FFF_1000: low bound of the IO-error window, inclusive.
- IO_ERR_HI, 30'h3FFF_10FF: high bound of the IO-error window, inclusive.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_l  in  1  asynchronous active-low reset.
- pj_tv  in  1  transaction valid; held high by the core until the last ack.
- pj_type  in  4  transaction type. [2:0] selects the beat count; [0]=1 means write.
- pj_size  in  2  access size; 2'b11 is illegal.
- pj_address  in  30  word address of the first beat.
- pj_data_out  in  32  store data from the core.
- pj_standby_out  in  1  core in standby.
- pj_ack  out  2  2'b00 none, 2'b01 beat ack, 2'b10 memory error, 2'b11 IO error.
- pj_data_in  out  32  load data; valid only in a read-ack cycle.
- err_pulse  out  1  one-cycle pulse on any error ack or rejected transaction.

Behaviour:
- Reset (asynchronous, reset_l=0): pj_ack=0, pj_data_in=0, err_pulse=0, FSM=IDLE, all counters cleared. Storage contents are not cleared.
- FSM states: IDLE, WAIT, BEAT, GAP.
- IDLE -> WAIT when pj_tv=1 and pj_standby_out=0. On that edge latch pj_type, pj_size, pj_address, and beats.
- Beats by pj_type[2:0]:
  - 000 -> 2
  - 010 -> 1
  - 100 -> 4
  - 101 -> 4
  - 110 -> 1
  - 111 -> 1
- Illegal type (001/011) or pj_size=2'b11: respond as a memory error.
- WAIT counts WAIT_STATES cycles, then enters BEAT. With WAIT_STATES=0, BEAT directly follows accept, so the first ack appears on the edge after accept.
- BEAT drives pj_ack=01 for exactly one cycle.
  - Read: pj_data_in = mem[addr].
  - Write: mem[addr] <= pj_data_out sampled in that cycle.
  - Then decrement beats. If more beats remain: go to GAP (BEAT_GAP>0) or stay in BEAT. Otherwise return to IDLE.
- Burst addressing: addr starts at the latched address and increments with wrap inside the aligned group.
  - 4-beat: wrap modulo 4, so start ...2 gives 2,3,0,1.
  - 2-beat: wrap modulo 2.
- Error windows are checked on the latched first address. Memory-error range takes priority if the windows overlap.
  - Memory-error window: after WAIT, drive a single pj_ack=10 plus err_pulse, then IDLE.
  - IO-error window: after WAIT, drive a single pj_ack=11 plus err_pulse, then IDLE.
  - No 01 acks are issued and no storage write occurs.
- Back-to-back: after the final ack the FSM is in IDLE. If pj_tv is still high on the next edge, that edge accepts a new transaction. The bus therefore has a minimum of one ack-free cycle between transactions.
- Abort: pj_tv=0 in WAIT/BEAT/GAP returns the FSM to IDLE on that edge. No further acks; writes already performed are kept.
- Standby:
  - pj_tv=1 with pj_standby_out=1 in IDLE is ignored, and err_pulse is asserted once per such cycle.
  - Standby rising mid-transaction does not abort the transaction.
- pj_data_in = 0 whenever pj_ack != 01 or the transaction is a write; never X.
- Reset mid-transaction: outputs go to 0 immediately, and no pending acks are issued after release.

Test Plan:
- Preload mem[0x100]=32'hCAFE0001. Drive type=110, size=10, addr=0x100, WAIT_STATES=2. Required: single pj_ack=01 on the 3rd edge after accept, with pj_data_in=CAFE0001.
- Preload words 0x200..0x203 = A0..A3. Drive type=100, addr=0x202. Required: four consecutive 01 acks returning A2,A3,A0,A1, then IDLE.
- Drive type=101 with 4 writes, data 1,2,3,4, to addr=0x300, BEAT_GAP=1. Required: acks spaced 2 cycles apart; readback of 0x300..0x303 = 1,2,3,4.
- Drive addr=MEM_ERR_LO, type=110. Required: one pj_ack=10 plus err_pulse, no 01 acks. Then drive addr=IO_ERR_HI, type=111. Required: one pj_ack=11 plus err_pulse, and no storage write.
- Drive type=000, addr=0x41, with pj_tv dropped after the first ack. Required: exactly one 01 ack, then IDLE. Then drive a type=010 with pj_tv held. Required: it is accepted on the next edge and returns 1 ack.
- Assert reset_l=0 during the WAIT of a 4-beat read. Required: pj_ack=00 and pj_data_in=0 immediately, and no acks after release until a new pj_tv.
